// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the simddr port arbiter and simddr users.
package ddr_arb_pkg;

  localparam int DDR_INDEX_W      = 64;
  localparam int DDR_DATA_W       = 512;
  localparam int DDR_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} arb_owner_e;

endpackage

// File: rtl/ddr_port_arbiter.sv
// Shares the single simddr port between fetch (burst reads) and data (loads/stores).
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
//   state | meaning
//   IDLE  | arbitrate when ddr_ready and a request is present
//   ISSUE | one-cycle chip-enable with latched fields
//   WAIT  | fields held, waiting for ddr_operation_done
//   RESP  | owner's done pulse; requests ignored this cycle
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int INDEX_W      = DDR_INDEX_W,
  parameter int DATA_W       = DDR_DATA_W,
  parameter int STARVE_LIMIT = DDR_STARVE_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_req,
  input  logic [INDEX_W-1:0] if_index,
  input  logic               if_flush,
  output logic               if_done,
  output logic [DATA_W-1:0]  if_rdata,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [INDEX_W-1:0] mem_index,
  input  logic [DATA_W-1:0]  mem_wmask,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_done,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               ddr_chip_enable,
  output logic [INDEX_W-1:0] ddr_index,
  output logic               ddr_write_enable,
  output logic               ddr_burst_mode,
  output logic [DATA_W-1:0]  ddr_write_mask,
  output logic [DATA_W-1:0]  ddr_write_data,
  input  logic [DATA_W-1:0]  ddr_read_data,
  input  logic               ddr_operation_done,
  input  logic               ddr_ready,
  output logic               arb_busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e       state, state_d;
  arb_owner_e       owner, owner_d;
  logic             flush_pending, flush_d;
  logic [CNT_W-1:0] starve_cnt, starve_d;
  logic             if_done_q, if_done_d, mem_done_d, chip_enable_d;
  logic             if_valid, mem_wins, latch, capture;

  assign if_valid = if_req & ~if_flush;
  assign mem_wins = mem_req & ~(if_valid & (starve_cnt == LIMIT_C));

  always_comb begin
    state_d       = state;
    owner_d       = owner;
    flush_d       = flush_pending;
    starve_d      = starve_cnt;
    chip_enable_d = 1'b0;
    if_done_d     = 1'b0;
    mem_done_d    = 1'b0;
    latch         = 1'b0;
    capture       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!if_req) starve_d = '0;
        if (ddr_ready && (if_valid || mem_req)) begin
          latch         = 1'b1;
          chip_enable_d = 1'b1;
          flush_d       = 1'b0;
          state_d       = ISSUE;
          if (mem_wins) begin
            owner_d = OWN_MEM;
            if (if_req && starve_cnt != LIMIT_C) starve_d = starve_cnt + 1'b1;
          end else begin
            owner_d  = OWN_IF;
            starve_d = '0;
          end
        end
      end
      ISSUE: begin
        if (owner == OWN_IF && if_flush) flush_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (owner == OWN_IF && if_flush) flush_d = 1'b1;
        if (ddr_operation_done) begin
          capture    = 1'b1;
          state_d    = RESP;
          if_done_d  = (owner == OWN_IF) && !flush_d;
          mem_done_d = (owner == OWN_MEM);
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      owner           <= OWN_NONE;
      flush_pending   <= 1'b0;
      starve_cnt      <= '0;
      ddr_chip_enable <= 1'b0;
      if_done_q       <= 1'b0;
      mem_done        <= 1'b0;
      arb_busy        <= 1'b0;
    end else begin
      state           <= state_d;
      owner           <= owner_d;
      flush_pending   <= flush_d;
      starve_cnt      <= starve_d;
      ddr_chip_enable <= chip_enable_d;
      if_done_q       <= if_done_d;
      mem_done        <= mem_done_d;
      arb_busy        <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ddr_index        <= '0;
      ddr_write_enable <= 1'b0;
      ddr_burst_mode   <= 1'b0;
      ddr_write_mask   <= '0;
      ddr_write_data   <= '0;
      if_rdata         <= '0;
      mem_rdata        <= '0;
    end else begin
      if (latch) begin
        ddr_index        <= mem_wins ? mem_index : if_index;
        ddr_write_enable <= mem_wins & mem_we;
        ddr_burst_mode   <= ~mem_wins;
        ddr_write_mask   <= (mem_wins && mem_we) ? mem_wmask : '0;
        ddr_write_data   <= (mem_wins && mem_we) ? mem_wdata : '0;
      end
      if (capture && owner == OWN_IF)  if_rdata  <= ddr_read_data;
      if (capture && owner == OWN_MEM) mem_rdata <= ddr_read_data;
    end
  end

  // A redirect arriving in the done cycle itself still cancels the fetch pulse.
  assign if_done = if_done_q & ~if_flush;

endmodule
